cache_lookup_ctrl: RTL and testbench
====================================

# cache_lookup_ctrl

Lookup and miss-handling controller for the 2-way set-associative cache. It latches a CPU read request and compares its 25-bit tag against both ways' tag registers and valid bits. On a hit it responds; on a miss it fetches a 4-word line from memory, then drives the tag/data write strobes, way select and `miss` enable into the tag and data arrays. It sits directly upstream of the per-way tag registers and owns the per-set LRU state.

## Interface
Parameters:
- TAG_W, 25, tag width (address bits 31:7)
- IDX_W, 3, set index width (address bits 6:4), 8 sets
- OFF_W, 4, byte offset width (address bits 3:0), 16-byte line
- BEATS, 4, 32-bit memory beats per line refill

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU read request
- req_addr  in  32  CPU byte address
- req_ready  out  1  controller can accept a request (IDLE only)
- resp_valid  out  1  one-cycle pulse: read data valid
- resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = served after refill
- tag_q0, tag_q1  in  25  tag register outputs, way 0 / way 1
- valid0, valid1  in  1  valid bit of the addressed set, per way
- set_idx  out  3  set being accessed (drives array decoders)
- way_sel  out  2  one-hot way for array read mux / write decode
- tagWrite  out  1  tag write strobe
- dataWrite  out  1  data word write strobe
- word_sel  out  2  word within line for dataWrite
- miss  out  1  array miss-enable, high during refill and update
- mem_req  out  1  memory line request, held until mem_ack
- mem_addr  out  32  line-aligned address ({tag, idx, 4'b0})
- mem_ack  in  1  memory accepted request
- mem_rvalid  in  1  one refill beat present on memory data bus

## Operation
- States are IDLE, COMPARE, MISS_REQ, REFILL, UPDATE and RESPOND. The state register and LRU reset asynchronously to IDLE / all-zero.
- **IDLE:** req_ready=1. When req_valid is high, the controller latches req_addr into addr_r and moves to COMPARE.
- **COMPARE:** Compute hit0 = valid0 & (tag_q0==addr_r[31:7]); hit1 likewise.
  - hit0 | hit1: way_sel = hit way, resp_valid=1, resp_hit=1. LRU[set] = ~hit way (the other way becomes LRU). Next state IDLE.
  - If hit0 and hit1 are both set (illegal), way 0 wins.
  - Otherwise choose the victim: the first invalid way (way 0 preferred), else way LRU[set]. Register it in victim_r and go to MISS_REQ.
- **MISS_REQ:** mem_req=1 and mem_addr is driven. On mem_ack, go to REFILL and clear beat_cnt to 0.
- **REFILL:** miss=1 and way_sel=victim_r. Each mem_rvalid asserts dataWrite for that cycle with word_sel=beat_cnt, then beat_cnt increments. On the beat where beat_cnt==BEATS-1, go to UPDATE. Cycles without mem_rvalid are stalls with no writes.
- **UPDATE:** miss=1, tagWrite=1 and way_sel=victim_r for exactly one cycle. The array writes addr_r[31:7] and sets valid. LRU[set] = ~victim_r. Next state RESPOND.
- **RESPOND:** resp_valid=1, resp_hit=0 and way_sel=victim_r, for one cycle. Next state IDLE.
- set_idx = addr_r[6:4] in every state except IDLE, where it is 0.
- Reset values: all strobes, mem_req, resp_valid and resp_hit are 0; req_ready=1; way_sel=2'b00; addr_r=0.

## Timing
- Hit latency: accept in cycle N, resp_valid in N+1.
- Miss latency: 1 (COMPARE) + request wait + BEATS rvalid cycles + 1 (UPDATE) + 1 (RESPOND). With immediate ack and back-to-back rvalid this is 8 cycles from accept.
- All outputs are decoded from registered state plus addr_r/victim_r. Tag inputs are sampled combinationally in COMPARE only.
- mem_rvalid outside REFILL is ignored. mem_ack outside MISS_REQ is ignored.
- Requests arriving while req_ready=0 are not accepted. The requester holds them.
- A reset asserted mid-refill returns the block to IDLE immediately. No tagWrite is issued, so a partial line never becomes valid.

## Structure
- Shared package cache_pkg holds TAG_W, IDX_W, OFF_W, BEATS, the state enum and the address field slice helpers. The package is shared with the tag and data array wrappers.
- One sub-module: cache_lru, an 8×1-bit LRU store with asynchronous reset, a read port and a write-enable update port.

## Test plan
- **Cold miss.** Reset, then request 0x0000_1230. Expect victim way 0 and mem_addr 0x0000_1230. After 4 rvalid beats, dataWrite fires at word_sel 0..3, then tagWrite with way_sel 2'b01 and set 3. resp_hit=0 follows 8 cycles after accept.
- **Hit after fill.** Repeat request 0x0000_1234 with tag_q0=0x000_0024 and valid0=1. Expect resp_valid and resp_hit 1 cycle later, way_sel 2'b01, and LRU[3]=1.
- **LRU eviction.** Fill both ways of set 3, then access way 0. A new tag miss must select way 1. The next conflicting miss then selects way 0.
- **Stalled refill.** Insert gaps: rvalid on cycles 1, 3, 4 and 7 after ack. Expect exactly 4 dataWrites at word_sel 0,1,2,3. UPDATE follows the last beat.
- **Reset mid-refill.** Assert reset after beat 2. Expect IDLE, req_ready=1 and miss=0 at once, with tagWrite never asserted.
- **Stray handshakes.** mem_rvalid and mem_ack pulsed in IDLE produce no strobes and no state change.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache geometry, controller state encoding and address field helpers.
// Also used by the tag and data array wrappers.
package cache_pkg;

  localparam int unsigned TAG_W = 25;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned OFF_W = 4;
  localparam int unsigned BEATS = 4;
  localparam int unsigned SETS  = 1 << IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_MISS_REQ,
    ST_REFILL,
    ST_UPDATE,
    ST_RESPOND
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU store: one bit per set naming the least-recently-used way.
// Combinational read port, synchronous write port, asynchronous clear.
module cache_lru #(
  parameter int unsigned SETS  = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_lru,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_lru
);

  logic [SETS-1:0] lru_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_q <= '0;
    end else if (we) begin
      lru_q[wr_idx] <= wr_lru;
    end
  end

  assign rd_lru = lru_q[rd_idx];

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Lookup and miss-handling controller for the 2-way set-associative cache.
// Latches a read request, compares tags, refills a line on miss and owns LRU.
module cache_lookup_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W = cache_pkg::TAG_W,
  parameter int unsigned IDX_W = cache_pkg::IDX_W,
  parameter int unsigned OFF_W = cache_pkg::OFF_W,
  parameter int unsigned BEATS = cache_pkg::BEATS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_hit,
  input  logic [TAG_W-1:0] tag_q0,
  input  logic [TAG_W-1:0] tag_q1,
  input  logic             valid0,
  input  logic             valid1,
  output logic [IDX_W-1:0] set_idx,
  output logic [1:0]       way_sel,
  output logic             tagWrite,
  output logic             dataWrite,
  output logic [1:0]       word_sel,
  output logic             miss,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic             mem_rvalid
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t state, state_next;

  logic [31:0]      addr_r;
  logic             victim_r;
  logic [CNT_W-1:0] beat_cnt;

  logic [TAG_W-1:0] tag_a;
  logic [IDX_W-1:0] idx_a;
  logic             hit0, hit1, hit_any;
  logic             lru_rd, lru_we, lru_wr;
  logic             victim_next;
  logic [1:0]       victim_oh;
  logic             unused_off;

  assign tag_a      = addr_r[31 -: TAG_W];
  assign idx_a      = addr_r[OFF_W +: IDX_W];
  assign unused_off = ^addr_r[OFF_W-1:0];

  assign hit0    = valid0 & (tag_q0 == tag_a);
  assign hit1    = valid1 & (tag_q1 == tag_a);
  assign hit_any = hit0 | hit1;

  // Invalid ways are filled first (way 0 preferred) before LRU is consulted.
  assign victim_next = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru_rd);
  assign victim_oh   = victim_r ? 2'b10 : 2'b01;

  // LRU bit holds the way to evict next, i.e. the way not just touched.
  assign lru_we = ((state == ST_COMPARE) && hit_any) || (state == ST_UPDATE);
  assign lru_wr = (state == ST_UPDATE) ? ~victim_r : hit0;

  cache_lru #(
    .SETS  (1 << IDX_W),
    .IDX_W (IDX_W)
  ) u_lru (
    .clk    (clk),
    .rst    (reset),
    .rd_idx (idx_a),
    .rd_lru (lru_rd),
    .we     (lru_we),
    .wr_idx (idx_a),
    .wr_lru (lru_wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (req_valid) state_next = ST_COMPARE;
      ST_COMPARE:  state_next = hit_any ? ST_IDLE : ST_MISS_REQ;
      ST_MISS_REQ: if (mem_ack) state_next = ST_REFILL;
      ST_REFILL:   if (mem_rvalid && (beat_cnt == LAST_BEAT)) state_next = ST_UPDATE;
      ST_UPDATE:   state_next = ST_RESPOND;
      ST_RESPOND:  state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r   <= '0;
      victim_r <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) && req_valid) begin
        addr_r <= req_addr;
      end
      if ((state == ST_COMPARE) && !hit_any) begin
        victim_r <= victim_next;
      end
      if ((state == ST_MISS_REQ) && mem_ack) begin
        beat_cnt <= '0;
      end else if ((state == ST_REFILL) && mem_rvalid) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    way_sel    = 2'b00;
    tagWrite   = 1'b0;
    dataWrite  = 1'b0;
    word_sel   = 2'b00;
    miss       = 1'b0;
    mem_req    = 1'b0;
    set_idx    = idx_a;
    mem_addr   = {addr_r[31:OFF_W], {OFF_W{1'b0}}};
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        set_idx   = '0;
      end
      ST_COMPARE: begin
        if (hit_any) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          way_sel    = hit0 ? 2'b01 : 2'b10;
        end
      end
      ST_MISS_REQ: mem_req = 1'b1;
      ST_REFILL: begin
        miss      = 1'b1;
        way_sel   = victim_oh;
        dataWrite = mem_rvalid;
        word_sel  = 2'(beat_cnt);
      end
      ST_UPDATE: begin
        miss     = 1'b1;
        tagWrite = 1'b1;
        way_sel  = victim_oh;
      end
      ST_RESPOND: begin
        resp_valid = 1'b1;
        way_sel    = victim_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Directed bench for cache_lookup_ctrl: per-cycle vector table for a cold
// miss and hit, then hand-written LRU, stall, reset and stray-handshake cases.
module tb_cache_lookup_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready, resp_valid, resp_hit;
  logic [24:0] tag_q0, tag_q1;
  logic        valid0, valid1;
  logic [2:0]  set_idx;
  logic [1:0]  way_sel;
  logic        tagWrite, dataWrite;
  logic [1:0]  word_sel;
  logic        miss, mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack, mem_rvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_lookup_ctrl #(.TAG_W(25), .IDX_W(3), .OFF_W(4), .BEATS(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .tag_q0(tag_q0), .tag_q1(tag_q1), .valid0(valid0), .valid1(valid1),
    .set_idx(set_idx), .way_sel(way_sel), .tagWrite(tagWrite),
    .dataWrite(dataWrite), .word_sel(word_sel), .miss(miss),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid)
  );

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [24:0] tq0, tq1;
    logic        v0, v1, ack, rval;
    logic        rdy, resp, hit;
    logic [2:0]  set;
    logic [1:0]  way;
    logic        tw, dw;
    logic [1:0]  ws;
    logic        ms, mreq;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic to_refill(input logic [31:0] addr, input logic [24:0] tq0, input logic v0,
                           input logic [24:0] tq1, input logic v1, input int ack_wait);
    req_valid = 1'b1;
    req_addr  = addr;
    #1 chk("acc_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tag_q0 = tq0; valid0 = v0; tag_q1 = tq1; valid1 = v1;
    #1 chk("cmp_no_resp", resp_valid, 0);
    chk("cmp_set", set_idx, addr[6:4]);
    tick();
    for (int i = 0; i < ack_wait; i++) begin
      #1 chk("req_hold", mem_req, 1);
      tick();
    end
    mem_ack = 1'b1;
    #1 chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, {addr[31:4], 4'h0});
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic run_miss(input logic [31:0] addr, input logic [24:0] tq0, input logic v0,
                          input logic [24:0] tq1, input logic v1, input logic [1:0] exp_way,
                          input logic [15:0] mask, input int ack_wait);
    int beat;
    to_refill(addr, tq0, v0, tq1, v1, ack_wait);
    beat = 0;
    for (int c = 0; c < 16 && beat < 4; c++) begin
      mem_rvalid = mask[c];
      #1 chk("refill_miss", miss, 1);
      chk("refill_way", way_sel, exp_way);
      chk("refill_tw", tagWrite, 0);
      chk("refill_dw", dataWrite, mask[c]);
      if (mask[c]) begin
        chk("refill_word", word_sel, beat[1:0]);
        beat++;
      end
      tick();
    end
    mem_rvalid = 1'b0;
    chk("beats_seen", beat, 4);
    #1 chk("upd_tw", tagWrite, 1);
    chk("upd_miss", miss, 1);
    chk("upd_way", way_sel, exp_way);
    chk("upd_dw", dataWrite, 0);
    chk("upd_set", set_idx, addr[6:4]);
    tick();
    #1 chk("rsp_valid", resp_valid, 1);
    chk("rsp_hit", resp_hit, 0);
    chk("rsp_way", way_sel, exp_way);
    chk("rsp_miss", miss, 0);
    tick();
    #1 chk("back_idle", req_ready, 1);
  endtask

  task automatic run_hit(input logic [31:0] addr, input logic [24:0] tq0, input logic v0,
                         input logic [24:0] tq1, input logic v1, input logic [1:0] exp_way);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    tag_q0 = tq0; valid0 = v0; tag_q1 = tq1; valid1 = v1;
    #1 chk("hit_valid", resp_valid, 1);
    chk("hit_flag", resp_hit, 1);
    chk("hit_way", way_sel, exp_way);
    chk("hit_miss", miss, 0);
    tick();
    #1 chk("hit_idle", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0;
    tag_q0 = '0; tag_q1 = '0; valid0 = 1'b0; valid1 = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0;

    //          rv addr          tq0    tq1 v0 v1 ak rv  rdy rsp hit set way    tw dw ws  ms mrq maddr
    vecs[0]  = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0};
    vecs[1]  = '{1, 32'h1230,    25'h0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0};
    vecs[2]  = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 0,  0, 0, 0, 3, 2'b00, 0, 0, 0, 0, 0, 32'h1230};
    vecs[3]  = '{0, 32'h0,       25'h0,  0, 0, 0, 1, 0,  0, 0, 0, 3, 2'b00, 0, 0, 0, 0, 1, 32'h1230};
    vecs[4]  = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 1,  0, 0, 0, 3, 2'b01, 0, 1, 0, 1, 0, 32'h1230};
    vecs[5]  = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 1,  0, 0, 0, 3, 2'b01, 0, 1, 1, 1, 0, 32'h1230};
    vecs[6]  = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 1,  0, 0, 0, 3, 2'b01, 0, 1, 2, 1, 0, 32'h1230};
    vecs[7]  = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 1,  0, 0, 0, 3, 2'b01, 0, 1, 3, 1, 0, 32'h1230};
    vecs[8]  = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 0,  0, 0, 0, 3, 2'b01, 1, 0, 0, 1, 0, 32'h1230};
    vecs[9]  = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 0,  0, 1, 0, 3, 2'b01, 0, 0, 0, 0, 0, 32'h1230};
    vecs[10] = '{1, 32'h1234,    25'h0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h1230};
    vecs[11] = '{0, 32'h0,       25'h24, 0, 1, 0, 0, 0,  0, 1, 1, 3, 2'b01, 0, 0, 0, 0, 0, 32'h1230};
    vecs[12] = '{0, 32'h0,       25'h0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h1230};

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Cold miss on 0x1230 then a hit on 0x1234; exact per-cycle latency.
    for (int i = 0; i < 13; i++) begin
      req_valid = vecs[i].rv; req_addr = vecs[i].addr;
      tag_q0 = vecs[i].tq0; tag_q1 = vecs[i].tq1;
      valid0 = vecs[i].v0;  valid1 = vecs[i].v1;
      mem_ack = vecs[i].ack; mem_rvalid = vecs[i].rval;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, vecs[i].rdy);
      chk($sformatf("v%0d_resp", i), resp_valid, vecs[i].resp);
      chk($sformatf("v%0d_hit", i), resp_hit, vecs[i].hit);
      chk($sformatf("v%0d_set", i), set_idx, vecs[i].set);
      chk($sformatf("v%0d_way", i), way_sel, vecs[i].way);
      chk($sformatf("v%0d_tw", i), tagWrite, vecs[i].tw);
      chk($sformatf("v%0d_dw", i), dataWrite, vecs[i].dw);
      chk($sformatf("v%0d_ws", i), word_sel, vecs[i].ws);
      chk($sformatf("v%0d_miss", i), miss, vecs[i].ms);
      chk($sformatf("v%0d_mreq", i), mem_req, vecs[i].mreq);
      chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].maddr);
      tick();
    end
    req_valid = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;

    // Fill way 1 (way 0 valid), touch way 0, then conflicting misses alternate.
    run_miss(32'h0000_2230, 25'h24, 1, 25'h00, 0, 2'b10, 16'hFFFF, 0);
    run_hit (32'h0000_1230, 25'h24, 1, 25'h44, 1, 2'b01);
    run_miss(32'h0000_3230, 25'h24, 1, 25'h44, 1, 2'b10, 16'b0000_0000_0100_1101, 1);
    run_miss(32'h0000_4230, 25'h24, 1, 25'h64, 1, 2'b01, 16'hFFFF, 0);
    run_hit (32'h0000_3230, 25'h84, 1, 25'h64, 1, 2'b10);
    run_hit (32'h0000_4230, 25'h84, 1, 25'h84, 1, 2'b01);

    // Reset after two beats: immediate IDLE, no tag write afterwards.
    to_refill(32'h0000_0050, 25'h0, 0, 25'h0, 0, 0);
    mem_rvalid = 1'b1;
    tick();
    tick();
    mem_rvalid = 1'b0;
    reset = 1'b1;
    #1 chk("rst_ready", req_ready, 1);
    chk("rst_miss", miss, 0);
    chk("rst_tw", tagWrite, 0);
    chk("rst_dw", dataWrite, 0);
    chk("rst_set", set_idx, 0);
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("post_rst_tw", tagWrite, 0);
      chk("post_rst_dw", dataWrite, 0);
      chk("post_rst_ready", req_ready, 1);
      tick();
    end
    mem_rvalid = 1'b0;

    // LRU was cleared by reset: set 3 now evicts way 0.
    run_miss(32'h0000_6230, 25'h24, 1, 25'h84, 1, 2'b01, 16'hFFFF, 0);

    // Stray memory handshakes while idle.
    mem_ack = 1'b1; mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stray_dw", dataWrite, 0);
      chk("stray_tw", tagWrite, 0);
      chk("stray_miss", miss, 0);
      chk("stray_mreq", mem_req, 0);
      chk("stray_ready", req_ready, 1);
      tick();
    end
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    #1 chk("stray_idle", req_ready, 1);
    chk("stray_resp", resp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
